// File: rtl/bcd_time_core_if.sv
// bcd_time_core_if: load, alarm and display signals of the BCD time-of-day core
interface bcd_time_core_if;
  logic       run;
  logic       mode24;
  logic       ld_valid;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic       ld_pm;
  logic       alm_wr;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;
  logic       alm_pm;
  logic       alm_en;
  logic [7:0] q_hour;
  logic [7:0] q_min;
  logic [7:0] q_sec;
  logic       pm;
  logic       sec_pulse;
  logic       ld_err;
  logic       alarm;
  modport master (
    output run, mode24, ld_valid, ld_sel, ld_data, ld_pm, alm_wr, alm_hour, alm_min, alm_pm, alm_en,
    input  q_hour, q_min, q_sec, pm, sec_pulse, ld_err, alarm
  );
  modport slave (
    input  run, mode24, ld_valid, ld_sel, ld_data, ld_pm, alm_wr, alm_hour, alm_min, alm_pm, alm_en,
    output q_hour, q_min, q_sec, pm, sec_pulse, ld_err, alarm
  );
endinterface

// File: rtl/bcd_time_core.sv
// bcd_time_core: BCD HH:MM:SS clock with 12h/24h mode, validated loads, hh:mm alarm and 1 Hz prescaler
module bcd_time_core #(
  parameter int          CLK_HZ     = 50000000,
  parameter logic [7:0]  RESET_HOUR = 8'h12
) (
  input logic             CLK,
  input logic             RST,
  bcd_time_core_if.slave  bus
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] alm_hour_q, alm_hour_d, alm_min_q, alm_min_d;
  logic mode_q, mode_d, pm_q, pm_d, alm_pm_q, alm_pm_d;
  logic sec_pulse_q, sec_pulse_d, ld_err_q, ld_err_d, alarm_q, alarm_d;
  logic tick, mode_chg, ld_ok, alm_ok, ld, adv, sec_c, hr_c, pm_n;
  logic [7:0] sec_n, min_n, hour_n, h24, h12;
  function automatic logic bcd_ok(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
  function automatic logic hour_ok(input logic [7:0] v, input logic m24);
    return bcd_ok(v) && (m24 ? v <= 8'h23 : v >= 8'h01 && v <= 8'h12);
  endfunction
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [6:0] to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction
  function automatic logic [7:0] to_bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction
  // next-state: mode conversion beats a valid load, which beats the tick advance
  always_comb begin
    tick = bus.run && cnt_q == CW'(CLK_HZ - 1);
    mode_chg = bus.mode24 != mode_q;
    ld_ok = bcd_ok(bus.ld_data) && (bus.ld_sel == 2'b10 ? hour_ok(bus.ld_data, mode_q) : bus.ld_sel != 2'b11 && bus.ld_data <= 8'h59);
    alm_ok = hour_ok(bus.alm_hour, mode_q) && bcd_ok(bus.alm_min) && bus.alm_min <= 8'h59;
    ld = bus.ld_valid && ld_ok && !mode_chg;
    adv = tick && !ld && !mode_chg;
    sec_c = sec_q == 8'h59;
    hr_c = sec_c && min_q == 8'h59;
    sec_n = sec_c ? 8'h00 : bcd_inc(sec_q);
    min_n = !sec_c ? min_q : hr_c ? 8'h00 : bcd_inc(min_q);
    hour_n = !hr_c ? hour_q : (hour_q == (mode_q ? 8'h23 : 8'h12)) ? (mode_q ? 8'h00 : 8'h01) : bcd_inc(hour_q);
    pm_n = mode_q ? hour_n >= 8'h12 : pm_q ^ (hr_c && hour_q == 8'h11);
    h24 = hour_q == 8'h12 ? (pm_q ? 8'h12 : 8'h00) : pm_q ? to_bcd(to_bin(hour_q) + 7'd12) : hour_q;
    h12 = hour_q == 8'h00 ? 8'h12 : hour_q > 8'h12 ? to_bcd(to_bin(hour_q) - 7'd12) : hour_q;
    cnt_d = (ld && bus.ld_sel == 2'b00) ? CW'(0) : !bus.run ? cnt_q : tick ? CW'(0) : cnt_q + CW'(1);
    mode_d = bus.mode24;
    sec_d = (ld && bus.ld_sel == 2'b00) ? bus.ld_data : adv ? sec_n : sec_q;
    min_d = (ld && bus.ld_sel == 2'b01) ? bus.ld_data : adv ? min_n : min_q;
    hour_d = mode_chg ? (bus.mode24 ? h24 : h12) : (ld && bus.ld_sel == 2'b10) ? bus.ld_data : adv ? hour_n : hour_q;
    pm_d = (ld && bus.ld_sel == 2'b10) ? (mode_q ? bus.ld_data >= 8'h12 : bus.ld_pm) : adv ? pm_n : pm_q;
    sec_pulse_d = adv;
    ld_err_d = (bus.ld_valid && !ld_ok) || (bus.alm_wr && !alm_ok);
    alarm_d = adv && bus.alm_en && hour_n == alm_hour_q && min_n == alm_min_q && sec_n == 8'h00 && (mode_q || pm_n == alm_pm_q);
    alm_hour_d = (bus.alm_wr && alm_ok) ? bus.alm_hour : alm_hour_q;
    alm_min_d = (bus.alm_wr && alm_ok) ? bus.alm_min : alm_min_q;
    alm_pm_d = (bus.alm_wr && alm_ok) ? bus.alm_pm : alm_pm_q;
  end
  // state registers; reset picks the hour format from MODE24 as sampled now
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      mode_q <= bus.mode24;
      hour_q <= bus.mode24 ? 8'h00 : RESET_HOUR;
      min_q <= 8'h00;
      sec_q <= 8'h00;
      pm_q <= 1'b0;
      alm_hour_q <= bus.mode24 ? 8'h00 : 8'h12;
      alm_min_q <= 8'h00;
      alm_pm_q <= 1'b0;
      sec_pulse_q <= 1'b0;
      ld_err_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      hour_q <= hour_d;
      min_q <= min_d;
      sec_q <= sec_d;
      pm_q <= pm_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q <= alm_min_d;
      alm_pm_q <= alm_pm_d;
      sec_pulse_q <= sec_pulse_d;
      ld_err_q <= ld_err_d;
      alarm_q <= alarm_d;
    end
  end
  assign bus.q_hour = hour_q;
  assign bus.q_min = min_q;
  assign bus.q_sec = sec_q;
  assign bus.pm = pm_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.ld_err = ld_err_q;
  assign bus.alarm = alarm_q;
endmodule

// File: tb/tb_bcd_time_core.sv
// tb_bcd_time_core: directed and random checks of bcd_time_core against a seconds-of-day model
module tb_bcd_time_core;
  logic clk, rst;
  int errs, checks;
  int t, pc;
  bit md;
  logic [7:0] ah, am;
  bit ap;
  bcd_time_core_if bus();
  bcd_time_core #(.CLK_HZ(4)) dut (.CLK(clk), .RST(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int bin(input logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction
  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction
  function automatic bit fld_ok(input logic [1:0] sel, input logic [7:0] d, input bit m24);
    if (d[7:4] > 4'd9 || d[3:0] > 4'd9 || sel == 2'b11) return 0;
    if (sel == 2'b10) return m24 ? bin(d) <= 23 : (bin(d) >= 1 && bin(d) <= 12);
    return bin(d) <= 59;
  endfunction
  function automatic logic [7:0] dh(input int tt, input bit m24);
    int h;
    h = tt / 3600;
    return m24 ? bcd(h) : bcd(h % 12 == 0 ? 12 : h % 12);
  endfunction
  // one clock: predict from the inputs now on the bus, then compare after the edge
  task automatic step();
    bit tick, mchg, lok, aok, adv, esp, eerr, eal;
    int h, m, s, v;
    tick = bus.run && pc == 3;
    mchg = bus.mode24 != md;
    lok = bus.ld_valid && fld_ok(bus.ld_sel, bus.ld_data, md);
    aok = fld_ok(2'b10, bus.alm_hour, md) && fld_ok(2'b00, bus.alm_min, md);
    eerr = (bus.ld_valid && !lok) || (bus.alm_wr && !aok);
    adv = tick && !lok && !mchg;
    if (bus.run) pc = tick ? 0 : pc + 1;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    if (mchg) md = bus.mode24;
    else if (lok) begin
      v = bin(bus.ld_data);
      if (bus.ld_sel == 2'b00) begin s = v; pc = 0; end
      else if (bus.ld_sel == 2'b01) m = v;
      else h = md ? v : (v % 12) + (bus.ld_pm ? 12 : 0);
      t = h * 3600 + m * 60 + s;
    end else if (adv) t = (t + 1) % 86400;
    esp = adv;
    eal = adv && bus.alm_en && dh(t, md) == ah && bcd((t / 60) % 60) == am && t % 60 == 0 && (md || ((t / 3600 >= 12) == ap));
    if (bus.alm_wr && aok) begin ah = bus.alm_hour; am = bus.alm_min; ap = bus.alm_pm; end
    @(posedge clk); #1;
    chk("hour", bus.q_hour, dh(t, md));
    chk("min", bus.q_min, bcd((t / 60) % 60));
    chk("sec", bus.q_sec, bcd(t % 60));
    chk("pm", bus.pm, t / 3600 >= 12);
    chk("sec_pulse", bus.sec_pulse, esp);
    chk("ld_err", bus.ld_err, eerr);
    chk("alarm", bus.alarm, eal);
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    bus.ld_valid = 0;
    bus.alm_wr = 0;
    t = 0; pc = 0; md = bus.mode24;
    ah = md ? 8'h00 : 8'h12; am = 8'h00; ap = 0;
    chk("rst_hour", bus.q_hour, md ? 8'h00 : 8'h12);
    chk("rst_min", bus.q_min, 8'h00);
    chk("rst_sec", bus.q_sec, 8'h00);
    chk("rst_pm", bus.pm, 0);
    chk("rst_pulses", {bus.sec_pulse, bus.ld_err, bus.alarm}, 0);
  endtask
  task automatic ld(input logic [1:0] sel, input logic [7:0] d, input bit p);
    bus.ld_valid = 1; bus.ld_sel = sel; bus.ld_data = d; bus.ld_pm = p;
    step();
    bus.ld_valid = 0;
  endtask
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit p);
    ld(2'b10, h, p); ld(2'b01, m, 0); ld(2'b00, s, 0);
  endtask
  task automatic wait_tick();
    int n;
    n = 0;
    do begin step(); n++; end while (!bus.sec_pulse && n < 10);
    chk("tick_seen", bus.sec_pulse, 1);
  endtask
  initial begin
    int r;
    errs = 0; checks = 0;
    bus.run = 1; bus.mode24 = 0; bus.ld_valid = 0; bus.ld_sel = 0; bus.ld_data = 0; bus.ld_pm = 0;
    bus.alm_wr = 0; bus.alm_hour = 8'h12; bus.alm_min = 0; bus.alm_pm = 0; bus.alm_en = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (3) step();
    chk("first_tick_quiet", bus.sec_pulse, 0);
    step();
    chk("first_tick", bus.sec_pulse, 1);
    repeat (236) step();
    chk("60ticks_min", bus.q_min, 8'h01);
    chk("60ticks_hour", bus.q_hour, 8'h12);
    bus.run = 0;
    set_time(8'h11, 8'h59, 8'h59, 0);
    bus.run = 1;
    wait_tick();
    chk("roll11_hour", bus.q_hour, 8'h12);
    chk("roll11_pm", bus.pm, 1);
    bus.run = 0;
    set_time(8'h12, 8'h59, 8'h59, 1);
    bus.run = 1;
    wait_tick();
    chk("roll12_hour", bus.q_hour, 8'h01);
    chk("roll12_pm", bus.pm, 1);
    bus.run = 0;
    bus.mode24 = 1;
    step();
    chk("to24_hour", bus.q_hour, 8'h13);
    set_time(8'h23, 8'h59, 8'h59, 0);
    bus.run = 1;
    wait_tick();
    chk("roll23", {bus.q_hour, bus.q_min, bus.q_sec}, 24'h000000);
    bus.run = 0;
    ld(2'b10, 8'h24, 0);
    chk("bad24_err", bus.ld_err, 1);
    chk("bad24_hour", bus.q_hour, 8'h00);
    ld(2'b00, 8'h1A, 0);
    chk("nonbcd_err", bus.ld_err, 1);
    ld(2'b11, 8'h05, 0);
    chk("sel11_err", bus.ld_err, 1);
    bus.run = 1;
    for (int i = 0; i < 8 && pc != 3; i++) step();
    ld(2'b00, 8'h30, 0);
    chk("ldtick_sec", bus.q_sec, 8'h30);
    chk("ldtick_nopulse", bus.sec_pulse, 0);
    repeat (3) step();
    chk("ldtick_early", bus.sec_pulse, 0);
    step();
    chk("ldtick_next_pulse", bus.sec_pulse, 1);
    chk("ldtick_next_sec", bus.q_sec, 8'h31);
    bus.run = 0;
    bus.mode24 = 0;
    step();
    set_time(8'h03, 8'h15, 8'h00, 1);
    bus.mode24 = 1;
    step();
    chk("pm3_to24", bus.q_hour, 8'h15);
    bus.mode24 = 0;
    step();
    chk("15_to12_hour", bus.q_hour, 8'h03);
    chk("15_to12_pm", bus.pm, 1);
    ld(2'b10, 8'h12, 0);
    bus.mode24 = 1;
    step();
    chk("12am_to24", bus.q_hour, 8'h00);
    bus.mode24 = 0;
    step();
    chk("00_to12_hour", bus.q_hour, 8'h12);
    chk("00_to12_pm", bus.pm, 0);
    bus.alm_hour = 8'h07; bus.alm_min = 8'h30; bus.alm_pm = 0; bus.alm_wr = 1;
    step();
    bus.alm_wr = 0;
    bus.alm_en = 1;
    set_time(8'h07, 8'h29, 8'h59, 0);
    bus.run = 1;
    wait_tick();
    chk("alarm_fire", bus.alarm, 1);
    step();
    chk("alarm_one_cycle", bus.alarm, 0);
    bus.run = 0;
    bus.alm_en = 0;
    set_time(8'h07, 8'h29, 8'h59, 0);
    bus.run = 1;
    wait_tick();
    chk("alarm_disabled", bus.alarm, 0);
    bus.run = 0;
    bus.alm_en = 1;
    set_time(8'h07, 8'h29, 8'h59, 0);
    bus.run = 1;
    repeat (3) step();
    bus.run = 0;
    repeat (8) step();
    chk("frozen_sec", bus.q_sec, 8'h59);
    chk("frozen_pulse", bus.sec_pulse, 0);
    bus.mode24 = 1;
    bus.ld_valid = 1; bus.ld_sel = 2'b10; bus.ld_data = 8'h05;
    do_reset();
    bus.run = 1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      bus.ld_valid = 0; bus.alm_wr = 0;
      if (r == 0) begin
        bus.mode24 = !bus.mode24;
        step();
        continue;
      end
      bus.run = $urandom_range(0, 9) != 0;
      bus.ld_valid = $urandom_range(0, 7) == 0;
      bus.ld_sel = 2'($urandom_range(0, 3));
      bus.ld_pm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.ld_data = 8'($urandom);
      else if (bus.ld_sel == 2'b10) bus.ld_data = bcd($urandom_range(0, 23));
      else bus.ld_data = bcd($urandom_range(0, 1) == 0 ? $urandom_range(57, 59) : $urandom_range(0, 59));
      bus.alm_wr = $urandom_range(0, 15) == 0;
      bus.alm_hour = $urandom_range(0, 1) == 0 ? dh(t, md) : bcd($urandom_range(0, 23));
      bus.alm_min = $urandom_range(0, 1) == 0 ? bcd(((t / 60) + 1) % 60) : bcd($urandom_range(0, 59));
      bus.alm_pm = $urandom_range(0, 1) == 0 ? (t / 3600 >= 12) : 1'($urandom_range(0, 1));
      bus.alm_en = $urandom_range(0, 3) != 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
